// File: rtl/instruction_fetch_queue_if.sv
// Bus between the fetch queue, the program memory and the instruction decoder.
// master is the fetch-queue side; slave is the memory/decoder side.
interface instruction_fetch_queue_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] q_bytes;
    logic [3:0]  q_count;
    logic [31:0] q_pc;
    logic [2:0]  consume;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        fetch_end;
    logic        consume_err;

    modport master (
        output mem_addr, q_bytes, q_count, q_pc, fetch_end, consume_err,
        input  mem_data, consume, redirect, redirect_addr
    );

    modport slave (
        input  mem_addr, q_bytes, q_count, q_pc, fetch_end, consume_err,
        output mem_data, consume, redirect, redirect_addr
    );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: prefetches 4-byte words from program memory into a
// byte queue that the decoder drains 0-4 bytes per cycle.
module instruction_fetch_queue #(
    parameter int QDEPTH    = 8,
    parameter int MEM_BYTES = 256
) (
    input logic clk,
    input logic reset,
    instruction_fetch_queue_if.master bus
);
    localparam int          QW         = 8 * QDEPTH;
    localparam logic [31:0] LAST_FETCH = 32'(MEM_BYTES - 4);
    localparam logic [3:0]  PUSH_LIMIT = 4'(QDEPTH - 4);

    typedef enum logic {ST_RUN, ST_END} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   q_pc_q, q_pc_d;
    logic [3:0]    q_count_q, q_count_d;
    logic [QW-1:0] qvec_q, qvec_d;
    logic          consume_err_q, consume_err_d;

    logic [3:0]    cons_w;
    logic [3:0]    ce;
    logic [3:0]    rem;
    logic          consume_bad;
    logic          push;
    logic [QW-1:0] ins;

    // Head byte lives in the MSBs; bytes at or past q_count are always zero,
    // so shifting left retires bytes and OR-ing appends new ones.
    always_comb begin
        cons_w      = {1'b0, bus.consume};
        consume_bad = (cons_w > q_count_q) || (bus.consume > 3'd4);
        ce          = (bus.consume > 3'd4) ? 4'd4 : cons_w;
        if (ce > q_count_q) ce = q_count_q;
        rem  = q_count_q - ce;
        push = (state_q == ST_RUN) && !bus.redirect && (rem <= PUSH_LIMIT);
        ins  = {bus.mem_data, {(QW-32){1'b0}}} >> {rem, 3'b000};
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        q_pc_d        = q_pc_q;
        q_count_d     = q_count_q;
        qvec_d        = qvec_q;
        consume_err_d = consume_err_q;
        if (bus.redirect) begin
            state_d       = (bus.redirect_addr <= LAST_FETCH) ? ST_RUN : ST_END;
            fetch_pc_d    = bus.redirect_addr;
            q_pc_d        = bus.redirect_addr;
            q_count_d     = 4'd0;
            qvec_d        = '0;
            consume_err_d = 1'b0;
        end else begin
            if (consume_bad) consume_err_d = 1'b1;
            q_pc_d    = q_pc_q + {28'd0, ce};
            qvec_d    = qvec_q << {ce, 3'b000};
            q_count_d = rem;
            if (push) begin
                qvec_d     = qvec_d | ins;
                q_count_d  = rem + 4'd4;
                fetch_pc_d = fetch_pc_q + 32'd4;
                if ((fetch_pc_q + 32'd4) > LAST_FETCH) state_d = ST_END;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= 32'd0;
            q_pc_q        <= 32'd0;
            q_count_q     <= 4'd0;
            qvec_q        <= '0;
            consume_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            q_pc_q        <= q_pc_d;
            q_count_q     <= q_count_d;
            qvec_q        <= qvec_d;
            consume_err_q <= consume_err_d;
        end
    end

    assign bus.mem_addr    = fetch_pc_q;
    assign bus.q_bytes     = qvec_q[QW-1 -: 32];
    assign bus.q_count     = q_count_q;
    assign bus.q_pc        = q_pc_q;
    assign bus.fetch_end   = (state_q == ST_END);
    assign bus.consume_err = consume_err_q;
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Scoreboarded bench for instruction_fetch_queue: a byte-queue reference model
// predicts each cycle's outputs, a separate monitor compares them.
module tb_instruction_fetch_queue;
    localparam int QDEPTH    = 8;
    localparam int MEM_BYTES = 256;

    logic clk;
    logic reset;
    instruction_fetch_queue_if bus ();

    instruction_fetch_queue #(.QDEPTH(QDEPTH), .MEM_BYTES(MEM_BYTES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [MEM_BYTES];

    always_comb begin
        bus.mem_data = 32'd0;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a;
            a = bus.mem_addr + 32'(k);
            if (a < 32'(MEM_BYTES)) bus.mem_data[31-8*k -: 8] = mem[a[7:0]];
        end
    end

    typedef struct {
        logic [31:0] cnt;
        logic [31:0] qb;
        logic [31:0] qpc;
        logic [31:0] maddr;
        logic [31:0] fend;
        logic [31:0] cerr;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: an ordinary byte queue plus two address counters.
    logic [7:0]  mq[$];
    int unsigned m_qpc, m_fpc;
    bit          m_end, m_err;

    function automatic logic [7:0] memrd(input longint unsigned a);
        return (a < MEM_BYTES) ? mem[a] : 8'h00;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_qpc = 0; m_fpc = 0; m_end = 0; m_err = 0;
    endtask

    task automatic model_step(input int cons, input bit redir, input logic [31:0] raddr);
        int ce;
        bit do_push;
        if (redir) begin
            mq.delete();
            m_qpc = raddr; m_fpc = raddr; m_err = 0;
            m_end = (longint'(raddr) > MEM_BYTES - 4);
        end else begin
            ce = cons;
            if (ce > 4) ce = 4;
            if (ce > mq.size()) ce = mq.size();
            if (cons > mq.size() || cons > 4) m_err = 1;
            do_push = !m_end && ((mq.size() - ce) <= QDEPTH - 4);
            for (int i = 0; i < ce; i++) void'(mq.pop_front());
            m_qpc = m_qpc + ce;
            if (do_push) begin
                for (int k = 0; k < 4; k++) mq.push_back(memrd(longint'(m_fpc) + k));
                m_fpc = m_fpc + 4;
                if (m_fpc > MEM_BYTES - 4) m_end = 1;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.qb = 32'd0;
        for (int k = 0; k < 4; k++)
            if (k < mq.size()) e.qb[31-8*k -: 8] = mq[k];
        e.cnt   = 32'(mq.size());
        e.qpc   = m_qpc;
        e.maddr = m_fpc;
        e.fend  = {31'd0, m_end};
        e.cerr  = {31'd0, m_err};
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: outputs are sampled 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("q_count",     32'(bus.q_count),     e.cnt);
                chk("q_bytes",     bus.q_bytes,          e.qb);
                chk("q_pc",        bus.q_pc,             e.qpc);
                chk("mem_addr",    bus.mem_addr,         e.maddr);
                chk("fetch_end",   32'(bus.fetch_end),   e.fend);
                chk("consume_err", 32'(bus.consume_err), e.cerr);
            end
        end
    end

    task automatic cycle(input logic [2:0] c, input logic r, input logic [31:0] ra);
        bus.consume       = c;
        bus.redirect      = r;
        bus.redirect_addr = ra;
        model_step(int'(c), r, ra);
        exp_q.push_back(model_out());
        @(posedge clk);
        @(negedge clk);
        bus.consume  = 3'd0;
        bus.redirect = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mem_addr"},    bus.mem_addr,         32'd0);
        chk({tag, "_q_bytes"},     bus.q_bytes,          32'd0);
        chk({tag, "_q_count"},     32'(bus.q_count),     32'd0);
        chk({tag, "_q_pc"},        bus.q_pc,             32'd0);
        chk({tag, "_fetch_end"},   32'(bus.fetch_end),   32'd0);
        chk({tag, "_consume_err"}, 32'(bus.consume_err), 32'd0);
    endtask

    // Reset is raised mid-cycle, away from any edge, to show it acts at once.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b1;
        bus.consume  = 3'd0;
        bus.redirect = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pre [16];
        logic [31:0] ra;
        logic [2:0]  c;
        pre = '{8'h55, 8'h89, 8'hb8, 8'h02, 8'h00, 8'h00, 8'h00, 8'h5d,
                8'hc3, 8'he8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < MEM_BYTES; i++)
            mem[i] = (i < 16) ? pre[i] : 8'($urandom);
        reset             = 1'b0;
        bus.consume       = 3'd0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = 32'd0;
        model_reset();

        do_reset("reset");

        // Preload fill with consume held at zero
        cycle(3'd0, 1'b0, 32'd0);
        chk("fill1_q_bytes", bus.q_bytes, 32'h5589b802);
        cycle(3'd0, 1'b0, 32'd0);
        cycle(3'd0, 1'b0, 32'd0);
        chk("fill3_q_count", 32'(bus.q_count), 32'd8);
        chk("fill3_mem_addr", bus.mem_addr, 32'd8);
        cycle(3'd1, 1'b0, 32'd0);
        chk("pop1_q_bytes", bus.q_bytes, 32'h89b80200);
        chk("pop1_mem_addr", bus.mem_addr, 32'd8);

        // Full queue, pop 4 and push 4 together
        do_reset("reset2");
        repeat (3) cycle(3'd0, 1'b0, 32'd0);
        cycle(3'd4, 1'b0, 32'd0);
        chk("pop4_q_bytes", bus.q_bytes, 32'h0000005d);
        chk("pop4_mem_addr", bus.mem_addr, 32'd12);

        // Redirect overrides a simultaneous consume
        cycle(3'd3, 1'b1, 32'd9);
        chk("redir_q_pc", bus.q_pc, 32'd9);
        cycle(3'd0, 1'b0, 32'd0);
        chk("redir_q_bytes", bus.q_bytes, 32'he8000000);

        // Fetch stops at the end of memory; decoder drains
        cycle(3'd0, 1'b1, 32'h0000_00f8);
        repeat (4) cycle(3'd4, 1'b0, 32'd0);
        chk("end_fetch_end", 32'(bus.fetch_end), 32'd1);
        chk("end_mem_addr", bus.mem_addr, 32'h100);
        chk("end_q_pc", bus.q_pc, 32'h100);

        // Over-consume sets a sticky error cleared only by redirect
        cycle(3'd0, 1'b1, 32'h0000_00fc);
        cycle(3'd0, 1'b0, 32'd0);
        cycle(3'd2, 1'b0, 32'd0);
        cycle(3'd3, 1'b0, 32'd0);
        chk("err_set", 32'(bus.consume_err), 32'd1);
        repeat (2) cycle(3'd0, 1'b0, 32'd0);
        chk("err_sticky", 32'(bus.consume_err), 32'd1);
        cycle(3'd0, 1'b1, 32'd0);
        chk("err_cleared", 32'(bus.consume_err), 32'd0);

        // Asynchronous reset during a fill
        cycle(3'd0, 1'b0, 32'd0);
        do_reset("reset_midfill");

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            c = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                            : 3'($urandom_range(0, 4));
            case ($urandom_range(0, 3))
                0: ra = 32'($urandom_range(0, 255));
                1: ra = 32'($urandom_range(0, 63)) << 2;
                2: ra = 32'h0000_00f0 + 32'($urandom_range(0, 19));
                default: ra = $urandom;
            endcase
            cycle(c, ($urandom_range(0, 14) == 0), ra);
            if (n == 300) do_reset("reset_rand");
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
